// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM ROM-port arbiter.
// Holds the FSM state type, the select-width helper and the default read delay.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DATA,
        DONE
    } arb_state_t;

    // Controller CAS latency; the extra two cycles cover CAS->READ0 and the output register.
    localparam int unsigned CAS_LATENCY      = 3;
    localparam int unsigned RD_DELAY_DEFAULT = CAS_LATENCY + 2;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of pend scanning from rr_ptr upward, mod NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned SW   = 2
) (
    input  logic [NREQ-1:0] pend,
    input  logic [SW-1:0]   rr_ptr,
    output logic            gnt_valid,
    output logic [SW-1:0]   sel
);

    int unsigned idx;

    // Descending scan so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        sel       = '0;
        idx       = 0;
        gnt_valid = |pend;
        for (int unsigned i = NREQ; i > 0; i--) begin
            idx = (32'(rr_ptr) + i - 1) % NREQ;
            if (pend[idx]) begin
                sel = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/sdram_rom_arbiter.sv
// Shares the SDRAM controller's toggle-handshake ROM port between NREQ clients,
// one outstanding transaction at a time, round-robin granted.
module sdram_rom_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned AW       = 23,
    parameter int unsigned DW       = 16,
    parameter int unsigned RD_DELAY = RD_DELAY_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    cl_req,
    output logic [NREQ-1:0]    cl_ack,
    input  logic [NREQ-1:0]    cl_we,
    input  logic [NREQ*AW-1:0] cl_addr,
    input  logic [NREQ*DW-1:0] cl_din,
    output logic [DW-1:0]      cl_dout,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout,
    output logic               busy
);

    localparam int unsigned SW  = sel_width(NREQ);
    localparam int unsigned DLW = (RD_DELAY < 2) ? 1 : $clog2(RD_DELAY);

    arb_state_t      state, state_nxt;
    logic [SW-1:0]   sel, sel_nxt;
    logic [SW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [SW-1:0]   pick_sel;
    logic            gnt_valid;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] cl_ack_nxt;
    logic [DLW-1:0]  dly, dly_nxt;
    logic [DW-1:0]   cl_dout_nxt;
    logic            mem_req_nxt;
    logic            mem_we_nxt;
    logic [AW-1:0]   mem_addr_nxt;
    logic [DW-1:0]   mem_din_nxt;

    assign pend = cl_req ^ cl_ack;
    assign busy = (state != IDLE);

    rr_pick #(
        .NREQ (NREQ),
        .SW   (SW)
    ) u_rr_pick (
        .pend      (pend),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .sel       (pick_sel)
    );

    // The controller is not reset with us, so mem_req is re-aligned to its ack instead of cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            dly      <= '0;
            cl_ack   <= '0;
            cl_dout  <= '0;
            mem_req  <= mem_ack;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            rr_ptr   <= rr_ptr_nxt;
            dly      <= dly_nxt;
            cl_ack   <= cl_ack_nxt;
            cl_dout  <= cl_dout_nxt;
            mem_req  <= mem_req_nxt;
            mem_we   <= mem_we_nxt;
            mem_addr <= mem_addr_nxt;
            mem_din  <= mem_din_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        rr_ptr_nxt   = rr_ptr;
        dly_nxt      = dly;
        cl_ack_nxt   = cl_ack;
        cl_dout_nxt  = cl_dout;
        mem_req_nxt  = mem_req;
        mem_we_nxt   = mem_we;
        mem_addr_nxt = mem_addr;
        mem_din_nxt  = mem_din;

        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    sel_nxt      = pick_sel;
                    mem_we_nxt   = cl_we[pick_sel];
                    mem_addr_nxt = cl_addr[32'(pick_sel)*AW +: AW];
                    mem_din_nxt  = cl_din[32'(pick_sel)*DW +: DW];
                    state_nxt    = ISSUE;
                end
            end

            ISSUE: begin
                mem_req_nxt = ~mem_req;
                state_nxt   = WAIT_ACK;
            end

            WAIT_ACK: begin
                if (mem_ack == mem_req) begin
                    if (mem_we) begin
                        state_nxt = DONE;
                    end else begin
                        dly_nxt   = DLW'(RD_DELAY - 1);
                        state_nxt = WAIT_DATA;
                    end
                end
            end

            WAIT_DATA: begin
                if (dly == '0) begin
                    cl_dout_nxt = mem_dout;
                    state_nxt   = DONE;
                end else begin
                    dly_nxt = dly - 1'b1;
                end
            end

            DONE: begin
                // Ack with the live request level so a mid-flight re-toggle is absorbed.
                cl_ack_nxt[sel] = cl_req[sel];
                if (32'(sel) == NREQ - 1) begin
                    rr_ptr_nxt = '0;
                end else begin
                    rr_ptr_nxt = sel + 1'b1;
                end
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sdram_rom_arbiter.md
Name: sdram_rom_arbiter

Overview:
- Shares the SDRAM controller's single 16-bit ROM toggle port (rom_req/rom_req_ack) between NREQ clients, e.g. cartridge bus, ROM download/ioctl writer and co-processor fetch.
- Latches each client command and issues it downstream as one toggle.
- Waits out the controller's ack-to-data gap, returns read data, and acks the client with the same toggle protocol.
- Sits between the core clients and the SDRAM controller, in the SDRAM clock domain.

Parameters:
- NREQ, 3, number of clients (2..4).
- AW, 23, word address width (rom_addr[23:1]).
- DW, 16, data width.
- RD_DELAY, 5, clk cycles from observing mem_ack==mem_req to mem_dout valid (CAS→READ0 plus one register stage).

Ports:
- clk  in  1  SDRAM clock.
- reset  in  1  synchronous, active-high.
- cl_req  in  NREQ  per-client toggle request; pending when cl_req[i]^cl_ack[i].
- cl_ack  out  NREQ  per-client toggle ack.
- cl_we  in  NREQ  per-client write flag, sampled with request.
- cl_addr  in  NREQ*AW  packed word addresses, client i at [i*AW +: AW].
- cl_din  in  NREQ*DW  packed write data.
- cl_dout  out  DW  shared read-data register; valid for client i when cl_ack[i] toggles.
- mem_req  out  1  toggle to controller rom_req.
- mem_ack  in  1  controller rom_req_ack.
- mem_we  out  1  to rom_we.
- mem_addr  out  AW  to rom_addr.
- mem_din  out  DW  to rom_din.
- mem_dout  in  DW  from rom_dout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (while reset high, every cycle): cl_ack=0, cl_dout=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, state=IDLE, rr_ptr=0.
- mem_req <= mem_ack on every reset cycle. The controller is not reset with us, so this prevents a phantom downstream request.
- Clients must hold cl_req=0 during reset.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DATA, DONE.
- IDLE: pend = cl_req^cl_ack. If pend!=0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod NREQ. Latch sel, cl_we[sel], addr and din into mem_we/mem_addr/mem_din, then go to ISSUE.
- ISSUE: mem_req <= ~mem_req; go to WAIT_ACK. mem_* fields are stable from the cycle before the toggle until DONE.
- WAIT_ACK: when mem_ack==mem_req:
  - write → DONE;
  - read → load dly=RD_DELAY-1, go to WAIT_DATA.
- WAIT_DATA: decrement dly. At dly==0 capture cl_dout<=mem_dout and go to DONE.
- DONE: cl_ack[sel] <= cl_req[sel]; rr_ptr <= (sel+1) mod NREQ; go to IDLE.
- cl_dout is unchanged by writes.
- Latency from client toggle to ack toggle:
  - read: 4 + controller ack latency + RD_DELAY cycles;
  - write: 4 + controller ack latency.
- Only one downstream transaction is outstanding at a time; there is no pipelining.
- Fairness: a continuously requesting client is served at most once per NREQ grants while others are pending. No starvation.
- Simultaneous events:
  - A client re-toggling in the same cycle its ack toggles is seen as pending on the next IDLE.
  - A client toggling while it is being served: its req parity flips twice, so the arbiter acks with its current cl_req value. Clients must not re-toggle before their ack.
- cl_req changes for the selected client after latch do not affect the in-flight command.
- rr_ptr wraps from NREQ-1 to 0.
- Reset mid-operation: state is abandoned and mem_req resyncs to mem_ack. Any controller op already issued completes harmlessly; its data is discarded.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DATA, DONE);
  - width helper for sel (clog2 of NREQ);
  - default RD_DELAY constant tied to the controller's CAS latency.
- One sub-module is natural: rr_pick, a combinational round-robin first-set-bit picker (pend, rr_ptr → gnt_valid, sel).

Test Plan:
- Single read: client 1 toggles cl_req[1]=1, addr=0x012345, controller model acks after 3 cycles and drives mem_dout=0xBEEF RD_DELAY cycles later. Required: exactly one mem_req toggle with mem_addr=0x012345 and mem_we=0, then cl_dout=0xBEEF and cl_ack[1]=1.
- Write: client 0 cl_we=1, addr=0x000010, din=0xA55A. Required: mem_din=0xA55A and mem_we=1 at the toggle, cl_ack[0] toggles right after mem_ack, cl_dout unchanged.
- Contention: all three clients toggle in the same cycle with rr_ptr=0. Required grant order 0,1,2 and three mem_req toggles. A repeat burst with rr_ptr=1 gives order 1,2,0.
- Starvation: client 0 re-toggles immediately after every ack while client 2 has one pending request. Required: client 2 is granted within 2 transactions.
- Reset mid-read: assert reset in WAIT_DATA for 2 cycles. Required: mem_req==mem_ack after reset, cl_ack=0, busy=0, no spurious mem_req toggle after release.
- Back-to-back read then write from the same client. Required: no overlap, with the second mem_req toggle occurring only after the first cl_ack toggle.
